// File: rtl/rps_match_if.sv
// rps_match_if: move/strobe inputs and result/display outputs of the
// rock-paper-scissors match controller.
//   slave  : controller side (moves and strobes in, result and display out)
//   master : stimulus side (switch/button driver, board pins reader)
interface rps_match_if;
  logic [2:0] user;          // user move, one-hot 100/010/001
  logic [2:0] compu;         // computer move, same encoding
  logic       play;          // round commit strobe
  logic       new_match;     // restart match, any state
  logic       ready;         // play will be accepted
  logic [1:0] winornot;      // 10 user, 01 computer, 00 tie, 11 invalid
  logic       match_over;    // match finished
  logic [1:0] match_winner;  // 10 user, 01 computer, 00 not over
  logic       beep;          // buzzer drive
  logic [7:0] seg;           // segments of the active digit
  logic [3:0] COM;           // digit select, 1011 user / 1110 computer

  modport slave (
    input  user, compu, play, new_match,
    output ready, winornot, match_over, match_winner, beep, seg, COM
  );
  modport master (
    output user, compu, play, new_match,
    input  ready, winornot, match_over, match_winner, beep, seg, COM
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// rps_match_ctrl: judges rock-paper-scissors rounds, keeps both scores,
// ends a first-to-WIN_SCORE match, drives beep and the 2-digit scanned
// 7-segment score display. Single clock; counters replace divided clocks.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   bus      : rps_match_if.slave (moves, play/new_match in; ready,
//              winornot, match_over, match_winner, beep, seg, COM out)
// Optional build macro RPS_MATCH_BLINK_EN: winner digit blinks in OVER
// with BLINK_DIV-cycle phases; otherwise BLINK_DIV is unused.
module rps_match_ctrl #(
  parameter int unsigned WIN_SCORE   = 3,
  parameter int unsigned SCAN_DIV    = 250000,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned BEEP_CYCLES = 12500000,
  parameter int unsigned BLINK_DIV   = 12500000
) (
  input  logic        CLK,
  input  logic        RST,
  rps_match_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, JUDGE = 2'd1, HOLD = 2'd2, OVER = 2'd3} state_t;

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [3:0] COM_U = 4'b1011;
  localparam logic [3:0] COM_C = 4'b1110;
  localparam logic [7:0] BLANK = 8'b11111110;

  state_t            state_q, state_d;
  logic              ready_q, ready_d, over_q, over_d;
  logic [1:0]        win_q, win_d, res_q, res_d;
  logic [3:0]        usc_q, usc_d, csc_q, csc_d, com_q, com_d;
  logic [2:0]        mu_q, mu_d, mc_q, mc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
`ifdef RPS_MATCH_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               bph_q, bph_d;
`endif

  function automatic logic onehot3(input logic [2:0] m);
    return (m == 3'b100) || (m == 3'b010) || (m == 3'b001);
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] s);
    case (s)
      4'd0: digit = 8'b00000010;
      4'd1: digit = 8'b10011110;
      4'd2: digit = 8'b00100100;
      4'd3: digit = 8'b00001100;
      4'd4: digit = 8'b10011000;
      4'd5: digit = 8'b01001000;
      4'd6: digit = 8'b01000000;
      4'd7: digit = 8'b00011010;
      4'd8: digit = 8'b00000000;
      4'd9: digit = 8'b00001000;
      default: digit = BLANK;
    endcase
  endfunction

  logic uwin;
  assign uwin = (mu_q == 3'b100 && mc_q == 3'b010) || (mu_q == 3'b010 && mc_q == 3'b001) ||
                (mu_q == 3'b001 && mc_q == 3'b100);

  always_comb begin
    state_d = state_q; ready_d = ready_q; over_d = over_q; win_d = win_q;
    res_d = res_q; usc_d = usc_q; csc_d = csc_q; com_d = com_q;
    mu_d = mu_q; mc_d = mc_q; hold_d = hold_q; beep_d = beep_q; scan_d = scan_q;
`ifdef RPS_MATCH_BLINK_EN
    blink_d = blink_q; bph_d = bph_q;
    if (state_q == OVER) begin
      if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_d = '0;
        bph_d   = ~bph_q;
      end else blink_d = blink_q + 1'b1;
    end
`endif
    // free-running digit scan; an unexpected COM recovers to the user digit
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      com_d  = (com_q == COM_U) ? COM_C : COM_U;
    end else scan_d = scan_q + 1'b1;
    if (beep_q != '0) beep_d = beep_q - 1'b1;

    case (state_q)
      IDLE: if (bus.play) begin
        mu_d = bus.user; mc_d = bus.compu;
        state_d = JUDGE; ready_d = 1'b0;
      end
      JUDGE: begin
        state_d = HOLD;
        hold_d  = '0;
        if (!onehot3(mu_q) || !onehot3(mc_q)) res_d = 2'b11;
        else if (mu_q == mc_q) res_d = 2'b00;
        else if (uwin) begin
          res_d  = 2'b10;
          usc_d  = usc_q + 4'd1;
          beep_d = BEEP_W'(BEEP_CYCLES);
          if (usc_q + 4'd1 == WIN) begin
            state_d = OVER; over_d = 1'b1; win_d = 2'b10;
          end
        end else begin
          res_d = 2'b01;
          csc_d = csc_q + 4'd1;
          if (csc_q + 4'd1 == WIN) begin
            state_d = OVER; over_d = 1'b1; win_d = 2'b01;
          end
        end
`ifdef RPS_MATCH_BLINK_EN
        blink_d = '0; bph_d = 1'b0;
`endif
      end
      HOLD: if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
        state_d = IDLE; ready_d = 1'b1;
      end else hold_d = hold_q + 1'b1;
      default: ;  // OVER waits for new_match
    endcase

    // new_match overrides everything, including a same-cycle play
    if (bus.new_match) begin
      state_d = IDLE; ready_d = 1'b1; over_d = 1'b0; win_d = 2'b00;
      res_d = 2'b00; usc_d = '0; csc_d = '0; beep_d = '0; hold_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE; ready_q <= 1'b1; over_q <= 1'b0; win_q <= 2'b00;
      res_q <= 2'b00; usc_q <= '0; csc_q <= '0; com_q <= COM_U;
      mu_q <= '0; mc_q <= '0; hold_q <= '0; beep_q <= '0; scan_q <= '0;
`ifdef RPS_MATCH_BLINK_EN
      blink_q <= '0; bph_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; ready_q <= ready_d; over_q <= over_d; win_q <= win_d;
      res_q <= res_d; usc_q <= usc_d; csc_q <= csc_d; com_q <= com_d;
      mu_q <= mu_d; mc_q <= mc_d; hold_q <= hold_d; beep_q <= beep_d; scan_q <= scan_d;
`ifdef RPS_MATCH_BLINK_EN
      blink_q <= blink_d; bph_q <= bph_d;
`endif
    end
  end

  logic [7:0] seg_c;
  always_comb begin
    seg_c = BLANK;
    if (com_q == COM_U) begin
      seg_c = digit(usc_q);
`ifdef RPS_MATCH_BLINK_EN
      if (state_q == OVER && win_q == 2'b10 && bph_q) seg_c = BLANK;
`endif
    end else if (com_q == COM_C) begin
      seg_c = digit(csc_q);
`ifdef RPS_MATCH_BLINK_EN
      if (state_q == OVER && win_q == 2'b01 && bph_q) seg_c = BLANK;
`endif
    end
  end

  assign bus.ready        = ready_q;
  assign bus.winornot     = res_q;
  assign bus.match_over   = over_q;
  assign bus.match_winner = win_q;
  assign bus.beep         = (beep_q != '0);
  assign bus.seg          = seg_c;
  assign bus.COM          = com_q;
endmodule
